// File: rtl/profile_session_ctrl.sv
// profile_session_ctrl: validates a confirmed 3-bit profile code and runs the login session
//   clk, rst            clock, asynchronous active-high reset
//   profile             profile switches {A,B,C}, sampled on a confirm press
//   confirm, logout     debounced button levels; a press is a rising edge
//   session_active      high while a session is open
//   level               one-hot grant {adm, tester, user, guest}
//   err, locked         invalid-attempt and lockout indicators
//   tries               consecutive invalid attempts
// Outputs are registered images of the state, so they trail the state by one cycle.
module profile_session_ctrl #(
   parameter int MAX_TRIES      = 3,
   parameter int ERR_CYCLES     = 4,
   parameter int LOCK_CYCLES    = 16,
   parameter int SESSION_CYCLES = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] profile,
   input  logic       confirm,
   input  logic       logout,
   output logic       session_active,
   output logic [3:0] level,
   output logic       err,
   output logic       locked,
   output logic [1:0] tries
);
   localparam int MX = SESSION_CYCLES > LOCK_CYCLES ?
                       (SESSION_CYCLES > ERR_CYCLES ? SESSION_CYCLES : ERR_CYCLES) :
                       (LOCK_CYCLES > ERR_CYCLES ? LOCK_CYCLES : ERR_CYCLES);
   localparam int CW = MX > 2 ? $clog2(MX) : 1;

   typedef enum logic [2:0] {IDLE, CHECK, ACTIVE, ERROR, LOCKED} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [1:0]      tries_r, tries_n;
   logic [2:0]      code_r, code_n;
   logic [3:0]      lvl_r, lvl_n, grant;
   logic            confirm_q, logout_q;
   logic            c_press, l_press;

   assign c_press = confirm & ~confirm_q;
   assign l_press = logout & ~logout_q;
   assign grant = code_r == 3'b110 ? 4'b1000 :
                  code_r == 3'b101 ? 4'b0100 :
                  code_r == 3'b011 ? 4'b0010 :
                  code_r == 3'b001 ? 4'b0001 : 4'b0000;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      tries_n = tries_r;
      code_n  = code_r;
      lvl_n   = lvl_r;
      case (state)
         IDLE: begin
            if (c_press) begin
               code_n  = profile;
               state_n = CHECK;
            end
         end
         CHECK: begin
            cnt_n = '0;
            if (grant != 4'b0000) begin
               state_n = ACTIVE;
               lvl_n   = grant;
               tries_n = 2'd0;
            end else if (tries_r + 2'd1 == 2'(MAX_TRIES)) begin
               state_n = LOCKED;
               tries_n = 2'(MAX_TRIES);
            end else begin
               state_n = ERROR;
               tries_n = tries_r + 2'd1;
            end
         end
         ERROR: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(ERR_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end
         end
         LOCKED: begin
            cnt_n = cnt + 1'b1;
            if (cnt == CW'(LOCK_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
               tries_n = 2'd0;
            end
         end
         ACTIVE: begin
            // logout beats both a concurrent confirm and a concurrent timeout
            if (l_press) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else if (c_press) begin
               cnt_n = '0;
            end else if (cnt == CW'(SESSION_CYCLES - 1)) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= '0;
         tries_r        <= 2'd0;
         code_r         <= 3'b000;
         lvl_r          <= 4'b0000;
         // copies reset high so a button held through reset is not a press
         confirm_q      <= 1'b1;
         logout_q       <= 1'b1;
         session_active <= 1'b0;
         level          <= 4'b0000;
         err            <= 1'b0;
         locked         <= 1'b0;
         tries          <= 2'd0;
      end else begin
         state          <= state_n;
         cnt            <= cnt_n;
         tries_r        <= tries_n;
         code_r         <= code_n;
         lvl_r          <= lvl_n;
         confirm_q      <= confirm;
         logout_q       <= logout;
         session_active <= state == ACTIVE;
         level          <= state == ACTIVE ? lvl_r : 4'b0000;
         err            <= state == ERROR;
         locked         <= state == LOCKED;
         tries          <= tries_r;
      end
   end
endmodule

// File: tb/tb_profile_session_ctrl.sv
// tb_profile_session_ctrl: directed and random checks of profile_session_ctrl against a deadline-based model
module tb_profile_session_ctrl;
   localparam int S = 64, E = 4, L = 16, MT = 3;

   logic       clk = 0, rst = 1, confirm = 0, logout = 0;
   logic [2:0] profile = 3'b000;
   logic       session_active, err, locked;
   logic [3:0] level;
   logic [1:0] tries;
   int         checks = 0, errors = 0, n;

   profile_session_ctrl dut (
      .clk(clk), .rst(rst), .profile(profile), .confirm(confirm), .logout(logout),
      .session_active(session_active), .level(level), .err(err), .locked(locked), .tries(tries)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // model: phase plus the cycle number on which it ends, outputs trail by one cycle
   typedef enum {M_IDLE, M_CHECK, M_ACT, M_ERR, M_LOCK} mph_t;
   mph_t       ph = M_IDLE;
   int         cyc = 0, end_c = 0, m_tries = 0;
   logic [2:0] m_code = 3'b000;
   logic [3:0] m_grant = 4'b0000, g;
   logic [3:0] tbl [8] = '{4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd4, 4'd8, 4'd0};
   logic       cq = 1, lq = 1, cp, lp;
   int         e_act = 0, e_lvl = 0, e_err = 0, e_lock = 0, e_tries = 0;

   always @(posedge clk) begin
      if (rst) begin
         ph = M_IDLE; m_tries = 0; cq = 1; lq = 1;
         e_act = 0; e_lvl = 0; e_err = 0; e_lock = 0; e_tries = 0;
      end else begin
         e_act   = ph == M_ACT;
         e_lvl   = ph == M_ACT ? int'(m_grant) : 0;
         e_err   = ph == M_ERR;
         e_lock  = ph == M_LOCK;
         e_tries = m_tries;
         cp = confirm && !cq;
         lp = logout && !lq;
         cq = confirm;
         lq = logout;
         case (ph)
            M_IDLE: if (cp) begin m_code = profile; ph = M_CHECK; end
            M_CHECK: begin
               g = tbl[m_code];
               if (g != 0) begin ph = M_ACT; m_grant = g; m_tries = 0; end_c = cyc + S; end
               else if (m_tries + 1 == MT) begin ph = M_LOCK; m_tries = MT; end_c = cyc + L; end
               else begin ph = M_ERR; m_tries++; end_c = cyc + E; end
            end
            M_ERR: if (cyc == end_c) ph = M_IDLE;
            M_LOCK: if (cyc == end_c) begin ph = M_IDLE; m_tries = 0; end
            M_ACT: begin
               if (lp) ph = M_IDLE;
               else if (cp) end_c = cyc + S;
               else if (cyc == end_c) ph = M_IDLE;
            end
         endcase
      end
      cyc++;
   end

   always @(posedge clk) begin
      #1;
      chk("m_active", session_active, e_act);
      chk("m_level", level, e_lvl);
      chk("m_err", err, e_err);
      chk("m_locked", locked, e_lock);
      chk("m_tries", tries, e_tries);
   end

   task automatic step(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [2:0] p);
      @(negedge clk);
      profile = p;
      confirm = 1;
      step(1);
      confirm = 0;
   endtask

   task automatic lpress();
      @(negedge clk);
      logout = 1;
      step(1);
      logout = 0;
   endtask

   logic [2:0] lg [4] = '{3'b110, 3'b101, 3'b011, 3'b001};

   initial begin
      step(2);
      chk("rst_active", session_active, 0);
      chk("rst_level", level, 0);
      chk("rst_tries", tries, 0);
      @(negedge clk) rst = 0;
      press(3'b110); step(2);
      chk("adm_level", level, 8);
      chk("adm_active", session_active, 1);
      chk("adm_tries", tries, 0);
      lpress(); step(1);
      chk("logout_active", session_active, 0);
      chk("logout_level", level, 0);
      press(3'b111); step(2);
      chk("err_high", err, 1);
      chk("err_tries", tries, 1);
      n = 1;
      repeat (6) begin step(1); n += int'(err); end
      chk("err_len", n, E);
      press(3'b001); step(2);
      chk("guest_level", level, 1);
      chk("guest_tries", tries, 0);
      lpress(); step(2);
      press(3'b000); step(8);
      press(3'b010); step(8);
      press(3'b100); step(2);
      chk("lock_high", locked, 1);
      chk("lock_tries", tries, 3);
      n = 1;
      for (int i = 0; i < 20; i++) begin
         profile = 3'b110;
         confirm = (i < 8) && i[0];
         step(1);
         n += int'(locked);
      end
      chk("lock_len", n, L);
      chk("lock_exit_tries", tries, 0);
      chk("lock_ignored", session_active, 0);
      press(3'b101); step(2);
      chk("tester_level", level, 4);
      lpress(); step(2);
      press(3'b011); step(1);
      n = 0;
      for (int i = 0; i < 200 && (n == 0 || session_active); i++) begin
         step(1);
         n += int'(session_active);
      end
      chk("timeout_len", n, S);
      press(3'b011); step(1);
      n = 0;
      for (int i = 0; i < 300 && (n == 0 || session_active); i++) begin
         step(1);
         n += int'(session_active);
         confirm = (n == 39) && session_active;
      end
      confirm = 0;
      chk("extended_len", n, 40 + S);
      press(3'b110); step(2);
      profile = 3'b000; step(3);
      chk("profile_toggle_level", level, 8);
      @(negedge clk);
      confirm = 1; logout = 1;
      step(1);
      confirm = 0; logout = 0;
      step(1);
      chk("both_active", session_active, 0);
      @(negedge clk);
      rst = 1; confirm = 1; profile = 3'b000;
      step(2);
      @(negedge clk) rst = 0;
      step(6);
      chk("held_err", err, 0);
      chk("held_active", session_active, 0);
      confirm = 0; step(1);
      press(3'b000); step(8);
      press(3'b010); step(8);
      press(3'b100); step(3);
      chk("mid_lock_high", locked, 1);
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("async_locked", locked, 0);
      chk("async_tries", tries, 0);
      @(negedge clk) rst = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         rst = $urandom_range(0, 599) == 0;
         profile = $urandom_range(0, 1) ? lg[$urandom_range(0, 3)] : 3'($urandom_range(0, 7));
         if ((i / 300) % 2 == 0) begin
            confirm = $urandom_range(0, 3) == 0;
            logout = $urandom_range(0, 19) == 0;
         end else begin
            confirm = $urandom_range(0, 39) == 0;
            logout = 0;
         end
      end
      @(negedge clk);
      rst = 0; confirm = 0; logout = 0;
      step(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/profile_session_ctrl.md
# profile_session_ctrl

Session controller for the profile switches: samples the 3-bit profile code on a confirm press, validates it against the four legal profiles (ADM, TESTER, USER, GUEST) and opens a session with the matching access level. It counts failed attempts, flags errors, locks out after repeated failures, and closes the session on logout or inactivity timeout. It sits between the debounced board switches/buttons and the access-dependent logic and LEDs.

## Interface
- `MAX_TRIES`, 3: consecutive invalid attempts that trigger lockout (1..3).
- `ERR_CYCLES`, 4: cycles `err` stays high after one invalid attempt (≥1).
- `LOCK_CYCLES`, 16: cycles `locked` stays high (≥1).
- `SESSION_CYCLES`, 64: inactivity cycles before auto-logout (≥2).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `profile`  in  3  profile switches {A,B,C}, A = bit 2; sampled only on a confirm press.
- `confirm`  in  1  debounced confirm button, level; a press is its rising edge.
- `logout`  in  1  debounced logout button, level; a press is its rising edge.
- `session_active`  out  1  high while in ACTIVE.
- `level`  out  4  one-hot grant {adm, tester, user, guest} = bits 3..0; all zero outside ACTIVE.
- `err`  out  1  high in ERROR.
- `locked`  out  1  high in LOCKED.
- `tries`  out  2  current count of consecutive invalid attempts.

## Operation
- Legal codes: 110 → ADM, 101 → TESTER, 011 → USER, 001 → GUEST. The other four codes are invalid.
- Press detection: registered copies `confirm_q` and `logout_q`. Press = input 1 and copy 0. Both copies reset to 1, so a button held through reset release is not a press.
- States:
  - **IDLE**: a confirm press latches `profile` into `code_r` → CHECK. Logout presses are ignored.
  - **CHECK** (one cycle):
    - Valid code → ACTIVE; load the one-hot into `level`; clear `tries`.
    - Invalid code, `tries+1 == MAX_TRIES` → LOCKED; `tries` holds `MAX_TRIES`.
    - Any other invalid code → ERROR; `tries` increments.
  - **ERROR**: counts `ERR_CYCLES` cycles → IDLE. `tries` is kept.
  - **LOCKED**: counts `LOCK_CYCLES` cycles → IDLE; `tries` clears on exit.
  - **ACTIVE**:
    - Logout press → IDLE.
    - Otherwise the inactivity counter increments each cycle. A confirm press clears it and does not re-sample `profile`.
    - Counter reaching `SESSION_CYCLES-1` → IDLE.
- Presses in CHECK, ERROR and LOCKED are ignored (not queued). `profile` changes outside the confirm-press cycle have no effect, including changes during ACTIVE.
- Simultaneous events:
  - ACTIVE, logout press + confirm press in the same cycle: logout wins.
  - ACTIVE, logout press in the same cycle the timeout is reached: IDLE, single exit.
- All outputs are registered and decoded from state; no combinational path from inputs to outputs.

## Timing
- Reset (asynchronous): state IDLE; `session_active`=0, `level`=0000, `err`=0, `locked`=0, `tries`=0; all counters 0; `code_r`=000.
- Confirm press sampled at edge t: CHECK during t→t+1; ACTIVE/ERROR/LOCKED outputs valid after edge t+2. Latency from press to grant is 2 cycles.
- `err` is high for exactly `ERR_CYCLES` cycles; `locked` is high for exactly `LOCK_CYCLES` cycles. The next cycle is IDLE, and a press is accepted in that first IDLE cycle.
- Logout press sampled at edge t: `session_active`=0 and `level`=0000 after edge t+1.
- Timeout: with no confirm press, `session_active` is high for exactly `SESSION_CYCLES` cycles.
- `rst` asserted in any state: outputs clear immediately without waiting for a clock. A lockout in progress is cancelled and `tries` → 0.

## Test plan
- Reset then confirm with `profile`=110 → `level`=1000 and `session_active`=1 two cycles after the press; `tries`=0; logout press → all zero next cycle.
- Confirm with 111 → `err`=1 for 4 cycles, `tries`=1, then IDLE; confirm with 001 → `level`=0001, `tries`=0.
- Three consecutive invalid presses (000, 010, 100) → `err` twice, then `locked`=1 for 16 cycles, `tries`=3; presses during LOCKED ignored; after exit `tries`=0 and 101 yields `level`=0100.
- ACTIVE with code 011, no presses → `session_active` drops after exactly 64 cycles; repeat with a confirm press at cycle 40 → session lasts 40+64 cycles.
- ACTIVE: confirm and logout rise in the same cycle → session ends next cycle; `profile` toggled during ACTIVE → `level` unchanged.
- Hold `confirm`=1 across reset release → no CHECK entry; assert `rst` mid-LOCKED → `locked`=0 with no clock edge.
